input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
Upstream conditioning stage for the two-process Moore sequence FSM.
- Takes a raw asynchronous input (push-button or switch) and synchronises it to CLK.
- Filters bounce with a stable-count debouncer.
- Delivers a clean level, plus one-cycle rise and fall pulses, to drive the FSM's x1 input.
- Sits between the board pin and the FSM, in the same clock domain as the FSM.

Parameters:
- DEBOUNCE_CYCLES, 8, number of consecutive synchronised samples of a new level needed before Clean changes. Legal range is at least 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), counter width. Derived only; never overridden.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- CLR_n  input  1  reset, asynchronous and active-low. Asserting it resets all state immediately; deassertion is synchronous to CLK at system level.
- Raw  input  1  asynchronous, bouncy input from the pin.
- Clean  output  1  debounced level; drives FSM x1.
- Rise  output  1  one-cycle pulse when Clean goes 0->1.
- Fall  output  1  one-cycle pulse when Clean goes 1->0.

Behaviour:
- Synchroniser: two flops, sync1 <= Raw, then sync2 <= sync1. Only sync2 feeds the FSM. Both flops reset to 0.
- State register, 2 bits: LOW=00, WAIT_HI=01, HIGH=10, WAIT_LO=11. Reset state is LOW.
- Counter cnt, CNT_W bits, reset to 0.
- LOW:
  - sync2=1 -> WAIT_HI, cnt<=0.
  - Otherwise stay in LOW.
- WAIT_HI:
  - sync2=0 -> LOW, cnt<=0. Glitch rejected; no pulse.
  - sync2=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH, cnt<=0.
  - Otherwise cnt<=cnt+1.
- HIGH:
  - sync2=0 -> WAIT_LO, cnt<=0.
  - Otherwise stay in HIGH.
- WAIT_LO: mirror image of WAIT_HI.
  - sync2=1 -> HIGH.
  - sync2=0 and cnt==DEBOUNCE_CYCLES-1 -> LOW.
  - Otherwise cnt<=cnt+1.
- Counter rules: cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps. cnt is held at 0 in LOW and HIGH.
- Clean is registered. It is 1 in HIGH and WAIT_LO, and 0 in LOW and WAIT_HI, so it holds its old value during both WAIT states.
- Rise is registered and is 1 for exactly the one cycle following the WAIT_HI->HIGH transition.
- Fall is registered and is 1 for exactly the one cycle following the WAIT_LO->LOW transition.
- Rise and Fall are never high together. A Rise is never followed by another Rise without an intervening Fall.
- Latency: Raw first sampled high at edge 0 and held gives sync2=1 after edge 1 and WAIT_HI after edge 2. Clean=1 and Rise=1 appear after edge DEBOUNCE_CYCLES+2 (edge 10 at default). Rise returns to 0 after the next edge. Fall latency is symmetric.
- Reset values: Clean=0, Rise=0, Fall=0, state LOW, cnt 0, sync1=0, sync2=0.
- Reset mid-operation: Clean drops to 0 asynchronously on CLR_n falling, with no Fall pulse. Any partial count is discarded.
- Raw held high through reset: after release it is treated as a fresh rising input. Rise fires DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
- Illegal state encodings cannot occur. The default branch goes to LOW with Clean=0.

Test Plan:
- Reset: hold CLR_n=0 with Raw toggling for 5 cycles -> Clean=Rise=Fall=0 throughout.
- Clean rise: release CLR_n, then set Raw=1 before edge 0 and hold -> Clean=1 and Rise=1 after edge 10. Rise=0 after edge 11. Clean stays 1.
- Bounce rejection: with Clean=0, apply Raw = 1,1,1,0,1,1,0 per cycle, then 0 -> Clean stays 0 and Rise never asserts.
- Fall and glitch: from Clean=1, pulse Raw=0 for 3 cycles, then 1 -> Clean stays 1 with no Fall. Then Raw=0 held -> Fall=1 and Clean=0 after edge 10 relative to the first low sample.
- Reset mid-debounce: Raw=1, assert CLR_n=0 at edge 6, release two cycles later with Raw still 1 -> no Rise before reset. Rise fires 10 edges after the first post-release edge.
- Parameter sweep: DEBOUNCE_CYCLES=2 and 16 -> rise latency is 4 and 18 edges respectively, and cnt never reaches DEBOUNCE_CYCLES (checked by assertion).

Source files
------------

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a stable-count debouncer for a bouncy pin.
// Produces a registered clean level plus one-cycle rise and fall pulses.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 8,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic CLK,
    input  logic CLR_n,
    input  logic Raw,
    output logic Clean,
    output logic Rise,
    output logic Fall
);

    typedef enum logic [1:0] {
        LOW     = 2'b00,
        WAIT_HI = 2'b01,
        HIGH    = 2'b10,
        WAIT_LO = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             sync1;
    logic             sync2;
    logic             next_clean;
    logic             next_rise;
    logic             next_fall;

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= Raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state <= LOW;
            cnt   <= '0;
            Clean <= 1'b0;
            Rise  <= 1'b0;
            Fall  <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            Clean <= next_clean;
            Rise  <= next_rise;
            Fall  <= next_fall;
        end
    end

    // The counter only runs in the WAIT states and is cleared on every exit,
    // so it can never pass CNT_MAX or wrap.
    always_comb begin
        next_state = state;
        next_cnt   = '0;
        case (state)
            LOW: begin
                if (sync2) next_state = WAIT_HI;
            end
            WAIT_HI: begin
                if (!sync2) begin
                    next_state = LOW;
                end else if (cnt == CNT_MAX) begin
                    next_state = HIGH;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            HIGH: begin
                if (!sync2) next_state = WAIT_LO;
            end
            WAIT_LO: begin
                if (sync2) begin
                    next_state = HIGH;
                end else if (cnt == CNT_MAX) begin
                    next_state = LOW;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            default: begin
                next_state = LOW;
            end
        endcase
    end

    // Outputs are computed from the upcoming state so the registered level
    // and pulses line up with the state they describe.
    always_comb begin
        next_clean = (next_state == HIGH) || (next_state == WAIT_LO);
        next_rise  = (state == WAIT_HI) && (next_state == HIGH);
        next_fall  = (state == WAIT_LO) && (next_state == LOW);
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: reset, debounced rise/fall, bounce and
// glitch rejection, mid-debounce reset and latency at several depths.
module tb_input_debouncer;

    logic CLK;
    logic CLR_n;
    logic Raw;
    logic Clean, Rise, Fall;
    logic clean2, rise2, fall2;
    logic clean16, rise16, fall16;

    int checks = 0;
    int passes = 0;

    input_debouncer #(.DEBOUNCE_CYCLES(8)) dut (
        .CLK(CLK), .CLR_n(CLR_n), .Raw(Raw),
        .Clean(Clean), .Rise(Rise), .Fall(Fall)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(2)) dut2 (
        .CLK(CLK), .CLR_n(CLR_n), .Raw(Raw),
        .Clean(clean2), .Rise(rise2), .Fall(fall2)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(16)) dut16 (
        .CLK(CLK), .CLR_n(CLR_n), .Raw(Raw),
        .Clean(clean16), .Rise(rise16), .Fall(fall16)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        CLR_n = 1'b0;
        Raw   = 1'b0;
        step();
        step();
        CLR_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        CLR_n = 1'b0;
        Raw   = 1'b0;
        #2;
        for (int i = 0; i < 5; i++) begin
            Raw = ~Raw;
            step();
            checks++;
            if ({Clean, Rise, Fall} !== 3'b000)
                $display("[TB] FAIL reset_hold cycle %0d: Clean/Rise/Fall=%b%b%b expected 000", i, Clean, Rise, Fall);
            else
                passes++;
        end
    endtask

    task automatic test_rise();
        logic exp_clean, exp_rise;
        apply_reset();
        Raw = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            step();
            exp_clean = (e >= 10);
            exp_rise  = (e == 10);
            checks++;
            if (Clean !== exp_clean || Rise !== exp_rise || Fall !== 1'b0)
                $display("[TB] FAIL rise edge %0d: Clean=%b Rise=%b Fall=%b expected %b %b 0", e, Clean, Rise, Fall, exp_clean, exp_rise);
            else
                passes++;
        end
    endtask

    task automatic test_async_clear();
        #2;
        CLR_n = 1'b0;
        #1;
        checks++;
        if ({Clean, Rise, Fall} !== 3'b000)
            $display("[TB] FAIL async_clear: Clean/Rise/Fall=%b%b%b expected 000", Clean, Rise, Fall);
        else
            passes++;
        step();
        CLR_n = 1'b1;
    endtask

    task automatic test_bounce();
        logic [6:0] pattern;
        pattern = 7'b1110110;
        apply_reset();
        for (int i = 0; i < 19; i++) begin
            Raw = (i < 7) ? pattern[6 - i] : 1'b0;
            step();
            checks++;
            if (Clean !== 1'b0 || Rise !== 1'b0)
                $display("[TB] FAIL bounce cycle %0d: Clean=%b Rise=%b expected 0 0", i, Clean, Rise);
            else
                passes++;
        end
    endtask

    task automatic test_fall_glitch();
        logic exp_clean, exp_fall;
        apply_reset();
        Raw = 1'b1;
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (Clean !== 1'b1)
            $display("[TB] FAIL fall_setup: Clean=%b expected 1", Clean);
        else
            passes++;
        for (int i = 0; i < 15; i++) begin
            Raw = (i < 3) ? 1'b0 : 1'b1;
            step();
            checks++;
            if (Clean !== 1'b1 || Fall !== 1'b0 || Rise !== 1'b0)
                $display("[TB] FAIL low_glitch cycle %0d: Clean=%b Fall=%b Rise=%b expected 1 0 0", i, Clean, Fall, Rise);
            else
                passes++;
        end
        Raw = 1'b0;
        for (int e = 0; e <= 12; e++) begin
            step();
            exp_clean = (e < 10);
            exp_fall  = (e == 10);
            checks++;
            if (Clean !== exp_clean || Fall !== exp_fall || Rise !== 1'b0)
                $display("[TB] FAIL fall edge %0d: Clean=%b Fall=%b Rise=%b expected %b %b 0", e, Clean, Fall, Rise, exp_clean, exp_fall);
            else
                passes++;
        end
    endtask

    task automatic test_reset_mid();
        logic exp_clean, exp_rise;
        apply_reset();
        Raw = 1'b1;
        for (int e = 0; e < 6; e++) begin
            step();
            checks++;
            if (Rise !== 1'b0 || Clean !== 1'b0)
                $display("[TB] FAIL mid_pre edge %0d: Clean=%b Rise=%b expected 0 0", e, Clean, Rise);
            else
                passes++;
        end
        CLR_n = 1'b0;
        step();
        step();
        CLR_n = 1'b1;
        for (int e = 0; e <= 11; e++) begin
            step();
            exp_clean = (e >= 10);
            exp_rise  = (e == 10);
            checks++;
            if (Clean !== exp_clean || Rise !== exp_rise)
                $display("[TB] FAIL mid_post edge %0d: Clean=%b Rise=%b expected %b %b", e, Clean, Rise, exp_clean, exp_rise);
            else
                passes++;
        end
    endtask

    task automatic test_sweep();
        int lat8, lat2, lat16;
        int max8, max2, max16;
        lat8 = -1; lat2 = -1; lat16 = -1;
        max8 = 0; max2 = 0; max16 = 0;
        apply_reset();
        Raw = 1'b1;
        for (int e = 0; e < 40; e++) begin
            step();
            if (Rise && lat8 < 0) lat8 = e;
            if (rise2 && lat2 < 0) lat2 = e;
            if (rise16 && lat16 < 0) lat16 = e;
            if (int'(dut.cnt) > max8) max8 = int'(dut.cnt);
            if (int'(dut2.cnt) > max2) max2 = int'(dut2.cnt);
            if (int'(dut16.cnt) > max16) max16 = int'(dut16.cnt);
        end
        checks++;
        if (lat2 !== 4) $display("[TB] FAIL latency_2: got %0d expected 4", lat2); else passes++;
        checks++;
        if (lat8 !== 10) $display("[TB] FAIL latency_8: got %0d expected 10", lat8); else passes++;
        checks++;
        if (lat16 !== 18) $display("[TB] FAIL latency_16: got %0d expected 18", lat16); else passes++;
        checks++;
        if (max2 !== 1) $display("[TB] FAIL cnt_max_2: got %0d expected 1", max2); else passes++;
        checks++;
        if (max8 !== 7) $display("[TB] FAIL cnt_max_8: got %0d expected 7", max8); else passes++;
        checks++;
        if (max16 !== 15) $display("[TB] FAIL cnt_max_16: got %0d expected 15", max16); else passes++;
        checks++;
        if ({clean2, Clean, clean16} !== 3'b111)
            $display("[TB] FAIL sweep_clean: clean2/8/16=%b%b%b expected 111", clean2, Clean, clean16);
        else
            passes++;
    endtask

    initial begin
        CLR_n = 1'b0;
        Raw   = 1'b0;
        test_reset();
        test_rise();
        test_async_clear();
        test_bounce();
        test_fall_glitch();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
